mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_feeder.sv | 158 +++++++++++++++
 tb/tb_mac_feeder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// Streams (iact, wght) tap pairs from two small scratchpads to a MAC over a valid/ready link.
// Each window w presents taps k = 0..KERNEL_SIZE-1 as iact_spad[w+k] paired with wght_spad[k].
module mac_feeder #(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned KERNEL_SIZE   = 9,
   parameter int unsigned IACT_DEPTH    = 16
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [3:0]               wr_addr,
   input  logic [DATA_BITWIDTH-1:0] wr_data,
   input  logic                     start,
   input  logic [3:0]               n_windows,
   output logic [DATA_BITWIDTH-1:0] iact,
   output logic [DATA_BITWIDTH-1:0] wght,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_first,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int unsigned KW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int unsigned AW     = (IACT_DEPTH > 1) ? $clog2(IACT_DEPTH) : 1;
   localparam int unsigned MaxWin = IACT_DEPTH - KERNEL_SIZE + 1;

   typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;

   state_e                   state_q, state_d;
   logic [DATA_BITWIDTH-1:0] iact_spad_q [IACT_DEPTH];
   logic [DATA_BITWIDTH-1:0] iact_spad_d [IACT_DEPTH];
   logic [DATA_BITWIDTH-1:0] wght_spad_q [KERNEL_SIZE];
   logic [DATA_BITWIDTH-1:0] wght_spad_d [KERNEL_SIZE];
   logic [KW-1:0]            k_q, k_d, k_nxt;
   logic [3:0]               w_q, w_d, w_nxt;
   logic [3:0]               nwin_q, nwin_d;
   logic [DATA_BITWIDTH-1:0] iact_q, iact_d, wght_q, wght_d;
   logic                     valid_q, valid_d, first_q, first_d, last_q, last_d;
   logic                     err_q, err_d;
   logic                     load;
   logic [AW-1:0]            idx;

   always_comb begin
      state_d     = state_q;
      iact_spad_d = iact_spad_q;
      wght_spad_d = wght_spad_q;
      k_d         = k_q;
      w_d         = w_q;
      nwin_d      = nwin_q;
      iact_d      = iact_q;
      wght_d      = wght_q;
      valid_d     = valid_q;
      first_d     = first_q;
      last_d      = last_q;
      err_d       = 1'b0;
      load        = 1'b0;
      k_nxt       = '0;
      w_nxt       = '0;
      idx         = '0;

      case (state_q)
         StIdle: begin
            if (wr_en) begin
               if (!wr_sel) begin
                  iact_spad_d[wr_addr[AW-1:0]] = wr_data;
               end else if (32'(wr_addr) < KERNEL_SIZE) begin
                  wght_spad_d[wr_addr[KW-1:0]] = wr_data;
               end
            end
            if (start) begin
               if ((n_windows != 4'd0) && (32'(n_windows) <= MaxWin)) begin
                  nwin_d  = n_windows;
                  state_d = StStream;
                  load    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StStream: begin
            if (valid_q && out_ready) begin
               if (last_q && ((w_q + 4'd1) == nwin_q)) begin
                  valid_d = 1'b0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = StFinish;
               end else begin
                  load = 1'b1;
                  if (last_q) begin
                     w_nxt = w_q + 4'd1;
                  end else begin
                     k_nxt = k_q + KW'(1);
                     w_nxt = w_q;
                  end
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      // Register the pair for (w_nxt, k_nxt) so the outputs stay flop-driven.
      if (load) begin
         idx     = AW'(w_nxt) + AW'(k_nxt);
         k_d     = k_nxt;
         w_d     = w_nxt;
         iact_d  = iact_spad_q[idx];
         wght_d  = wght_spad_q[k_nxt];
         first_d = (k_nxt == '0);
         last_d  = (32'(k_nxt) == KERNEL_SIZE - 1);
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= StIdle;
         iact_spad_q <= '{default: '0};
         wght_spad_q <= '{default: '0};
         k_q         <= '0;
         w_q         <= '0;
         nwin_q      <= '0;
         iact_q      <= '0;
         wght_q      <= '0;
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         iact_spad_q <= iact_spad_d;
         wght_spad_q <= wght_spad_d;
         k_q         <= k_d;
         w_q         <= w_d;
         nwin_q      <= nwin_d;
         iact_q      <= iact_d;
         wght_q      <= wght_d;
         valid_q     <= valid_d;
         first_q     <= first_d;
         last_q      <= last_d;
         err_q       <= err_d;
      end
   end

   assign iact      = iact_q;
   assign wght      = wght_q;
   assign out_valid = valid_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign err       = err_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFinish);

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: each task drives one scenario and checks against
// hand-computed pair sequences, flags and control pulses.
module tb_mac_feeder;

   logic       clk = 1'b0;
   logic       rstN;
   logic       wr_en, wr_sel, start, out_ready;
   logic [3:0] wr_addr, n_windows;
   logic [7:0] wr_data, iact, wght;
   logic       out_valid, out_first, out_last, busy, done, err;

   int tests  = 0;
   int failed = 0;

   mac_feeder #(.DATA_BITWIDTH(8), .KERNEL_SIZE(9), .IACT_DEPTH(16)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .n_windows (n_windows),
      .iact      (iact),
      .wght      (wght),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = addr;
      wr_data = data;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 9; i++) begin
         wr(1'b0, 4'(i), 8'(i + 1));
         wr(1'b1, 4'(i), 8'(9 - i));
      end
   endtask

   task automatic pulse_start(input logic [3:0] n);
      start     = 1'b1;
      n_windows = n;
      step();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; n_windows = '0; out_ready = 1'b1;
      #3;
      tests++;
      if ({iact, wght, out_valid, out_first, out_last, busy, done, err} !== 22'd0) begin
         failed++;
         $display("FAIL reset_outputs: got %h want 0",
                  {iact, wght, out_valid, out_first, out_last, busy, done, err});
      end
      step(); step();
      rstN = 1'b1;
      step(); step();
      tests++;
      if ({iact, wght, out_valid, out_first, out_last, busy, done, err} !== 22'd0) begin
         failed++;
         $display("FAIL post_reset_quiet: got %h want 0",
                  {iact, wght, out_valid, out_first, out_last, busy, done, err});
      end
   endtask

   task automatic test_single_window();
      int sum;
      sum = 0;
      load_ramp();
      out_ready = 1'b1;
      pulse_start(4'd1);
      for (int i = 0; i < 9; i++) begin
         tests++;
         if (out_valid !== 1'b1 || iact !== 8'(i + 1) || wght !== 8'(9 - i) ||
             out_first !== (i == 0) || out_last !== (i == 8) || busy !== 1'b1) begin
            failed++;
            $display("FAIL single_pair%0d: got v=%b (%0d,%0d) f=%b l=%b want v=1 (%0d,%0d)",
                     i, out_valid, iact, wght, out_first, out_last, i + 1, 9 - i);
         end
         sum += int'(iact) * int'(wght);
         step();
      end
      tests++;
      if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
         failed++;
         $display("FAIL single_finish: got v=%b done=%b busy=%b want 0 1 1",
                  out_valid, done, busy);
      end
      step();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL single_idle: got done=%b busy=%b want 0 0", done, busy);
      end
      tests++;
      if (sum != 165) begin
         failed++;
         $display("FAIL single_sum: got %0d want 165", sum);
      end
   endtask

   task automatic test_multi_window();
      int lasts;
      int w;
      int k;
      lasts = 0;
      for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), 8'(i));
      for (int i = 0; i < 9; i++) wr(1'b1, 4'(i), 8'd1);
      out_ready = 1'b1;
      pulse_start(4'd8);
      for (int t = 0; t < 72; t++) begin
         w = t / 9;
         k = t % 9;
         tests++;
         if (out_valid !== 1'b1 || iact !== 8'(w + k) || wght !== 8'd1 ||
             out_first !== (k == 0) || out_last !== (k == 8)) begin
            failed++;
            $display("FAIL multi_t%0d: got v=%b (%0d,%0d) f=%b l=%b want v=1 (%0d,1)",
                     t, out_valid, iact, wght, out_first, out_last, w + k);
         end
         if (out_valid && out_last) lasts++;
         step();
      end
      tests++;
      if (out_valid !== 1'b0 || done !== 1'b1) begin
         failed++;
         $display("FAIL multi_finish: got v=%b done=%b want 0 1", out_valid, done);
      end
      tests++;
      if (lasts != 8) begin
         failed++;
         $display("FAIL multi_last_count: got %0d want 8", lasts);
      end
      step();
   endtask

   task automatic test_backpressure();
      int xfers;
      int holds;
      int e;
      xfers = 0;
      holds = 0;
      load_ramp();
      out_ready = 1'b1;
      pulse_start(4'd1);
      for (int c = 0; c < 12; c++) begin
         e = (c < 4) ? c : ((c <= 7) ? 4 : c - 3);
         tests++;
         if (out_valid !== 1'b1 || iact !== 8'(e + 1) || wght !== 8'(9 - e) ||
             out_first !== (e == 0) || out_last !== (e == 8)) begin
            failed++;
            $display("FAIL bp_c%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                     c, out_valid, iact, wght, e + 1, 9 - e);
         end
         if (iact == 8'd5 && wght == 8'd5) holds++;
         out_ready = !(c >= 4 && c <= 6);
         if (out_valid && out_ready) xfers++;
         step();
      end
      out_ready = 1'b1;
      tests++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL bp_finish: got done=%b v=%b want 1 0", done, out_valid);
      end
      tests++;
      if (xfers != 9 || holds != 4) begin
         failed++;
         $display("FAIL bp_counts: got xfers=%0d holds=%0d want 9 4", xfers, holds);
      end
      step();
   endtask

   task automatic test_err();
      logic [3:0] bad [2];
      bad[0] = 4'd0;
      bad[1] = 4'd9;
      for (int i = 0; i < 2; i++) begin
         pulse_start(bad[i]);
         tests++;
         if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL err_pulse_n%0d: got err=%b busy=%b v=%b want 1 0 0",
                     bad[i], err, busy, out_valid);
         end
         step();
         tests++;
         if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL err_clear_n%0d: got err=%b busy=%b v=%b want 0 0 0",
                     bad[i], err, busy, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      load_ramp();
      out_ready = 1'b1;
      pulse_start(4'd8);
      repeat (23) step();
      tests++;
      if (out_valid !== 1'b1 || iact !== 8'd8 || wght !== 8'd4) begin
         failed++;
         $display("FAIL mid_pre_reset: got v=%b (%0d,%0d) want v=1 (8,4)", out_valid, iact, wght);
      end
      #2 rstN = 1'b0;
      #1;
      tests++;
      if ({iact, wght, out_valid, out_first, out_last, busy, done, err} !== 22'd0) begin
         failed++;
         $display("FAIL mid_reset_outputs: got %h want 0",
                  {iact, wght, out_valid, out_first, out_last, busy, done, err});
      end
      step();
      rstN = 1'b1;
      step();
      pulse_start(4'd1);
      for (int i = 0; i < 9; i++) begin
         tests++;
         if (out_valid !== 1'b1 || iact !== 8'd0 || wght !== 8'd0) begin
            failed++;
            $display("FAIL cleared_pair%0d: got v=%b (%0d,%0d) want v=1 (0,0)",
                     i, out_valid, iact, wght);
         end
         step();
      end
      tests++;
      if (done !== 1'b1) begin
         failed++;
         $display("FAIL cleared_done: got %b want 1", done);
      end
      step();
   endtask

   task automatic test_stream_ignore();
      int dones;
      int errs;
      dones = 0;
      errs  = 0;
      load_ramp();
      out_ready = 1'b1;
      pulse_start(4'd1);
      for (int c = 0; c < 12; c++) begin
         if (c < 9) begin
            tests++;
            if (out_valid !== 1'b1 || iact !== 8'(c + 1) || wght !== 8'(9 - c)) begin
               failed++;
               $display("FAIL ign_pair%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                        c, out_valid, iact, wght, c + 1, 9 - c);
            end
         end
         if (done) dones++;
         if (err) errs++;
         wr_en     = (c == 3);
         wr_sel    = 1'b1;
         wr_addr   = 4'd3;
         wr_data   = 8'hAA;
         start     = (c == 3) || (c == 9);
         n_windows = 4'd1;
         step();
      end
      wr_en = 1'b0;
      start = 1'b0;
      tests++;
      if (dones != 1 || errs != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL ign_control: got dones=%0d errs=%0d busy=%b v=%b want 1 0 0 0",
                  dones, errs, busy, out_valid);
      end
      pulse_start(4'd1);
      repeat (3) step();
      tests++;
      if (out_valid !== 1'b1 || iact !== 8'd4 || wght !== 8'd6) begin
         failed++;
         $display("FAIL ign_spad_kept: got v=%b (%0d,%0d) want v=1 (4,6)", out_valid, iact, wght);
      end
      repeat (7) step();
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_multi_window();
      test_backpressure();
      test_err();
      test_reset_mid_stream();
      test_stream_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
